// File: rtl/pe_array_sched.sv
// pe_array_sched: job scheduler for the 2x16 PE array.
// Takes a job descriptor (A accumulators, K MAC steps each). Accepts operand
// beats with a valid/ready handshake and drives the array's add_number, keep
// and rounder_en controls in the same cycle as the beat. Counts rounder_valid
// returns to signal job completion. Operand data bypasses this block.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start                job request (sampled in IDLE only)
//   i_cfg_k_len[KW]        MAC steps per accumulator (K >= 1), latched on start
//   i_cfg_acc_num[4]       accumulators minus one (A = acc_num + 1)
//   i_abort                synchronous job kill
//   i_in_valid / o_in_ready  operand beat handshake
//   o_pe_add_number[4]     accumulator select to the array
//   o_pe_keep              hold all accumulators
//   o_pe_rounder_en        rounding request to the array
//   i_pe_rounder_valid     rounding result return from the array
//   o_busy, o_done, o_err  status: busy, completion pulse, sticky drain timeout
module pe_array_sched #(
  parameter int unsigned KW        = 8,
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [KW-1:0] i_cfg_k_len,
  input  logic [3:0]    i_cfg_acc_num,
  input  logic          i_abort,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic [3:0]    o_pe_add_number,
  output logic          o_pe_keep,
  output logic          o_pe_rounder_en,
  input  logic          i_pe_rounder_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int unsigned AW  = 4;
  localparam int unsigned RW  = 5;
  localparam int unsigned DCW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_ROUND,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state,     w_state_nxt;
  logic [KW-1:0]   r_k_len,     w_k_len_nxt;
  logic [AW-1:0]   r_acc_last,  w_acc_last_nxt;
  logic [AW-1:0]   r_acc_cnt,   w_acc_cnt_nxt;
  logic [KW-1:0]   r_k_cnt,     w_k_cnt_nxt;
  logic [RW-1:0]   r_ret_cnt,   w_ret_cnt_nxt;
  logic [DCW-1:0]  r_drain_cnt, w_drain_cnt_nxt;
  logic            r_err,       w_err_nxt;

  logic            w_busy;
  logic            w_fire;
  logic [RW-1:0]   w_acc_total;
  logic [RW-1:0]   w_ret_sum;

  // State and counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_acc_last  <= '0;
      r_acc_cnt   <= '0;
      r_k_cnt     <= '0;
      r_ret_cnt   <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k_len     <= w_k_len_nxt;
      r_acc_last  <= w_acc_last_nxt;
      r_acc_cnt   <= w_acc_cnt_nxt;
      r_k_cnt     <= w_k_cnt_nxt;
      r_ret_cnt   <= w_ret_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state, counter update and control decode
  always_comb begin
    w_state_nxt     = r_state;
    w_k_len_nxt     = r_k_len;
    w_acc_last_nxt  = r_acc_last;
    w_acc_cnt_nxt   = r_acc_cnt;
    w_k_cnt_nxt     = r_k_cnt;
    w_ret_cnt_nxt   = r_ret_cnt;
    w_drain_cnt_nxt = '0;
    w_err_nxt       = r_err;

    w_busy          = (r_state != S_IDLE);
    w_fire          = (r_state == S_MAC) && i_in_valid;
    w_acc_total     = RW'(r_acc_last) + RW'(1);
    // A return landing this very cycle counts toward completion in DRAIN
    w_ret_sum       = r_ret_cnt + RW'(i_pe_rounder_valid);

    o_in_ready      = (r_state == S_MAC);
    o_pe_add_number = ((r_state == S_MAC) || (r_state == S_ROUND)) ? r_acc_cnt : '0;
    o_pe_keep       = ~w_fire;
    o_pe_rounder_en = (r_state == S_ROUND);
    o_busy          = w_busy;
    o_done          = (r_state == S_DONE);
    o_err           = r_err;

    if (w_busy && i_pe_rounder_valid) begin
      w_ret_cnt_nxt = r_ret_cnt + RW'(1);
    end

    case (r_state)
      S_IDLE: begin
        // A zero-length job is silently dropped
        if (i_start && (i_cfg_k_len != '0)) begin
          w_k_len_nxt    = i_cfg_k_len;
          w_acc_last_nxt = i_cfg_acc_num;
          w_acc_cnt_nxt  = '0;
          w_k_cnt_nxt    = '0;
          w_ret_cnt_nxt  = '0;
          w_err_nxt      = 1'b0;
          w_state_nxt    = S_MAC;
        end
      end
      S_MAC: begin
        if (w_fire) begin
          if (r_k_cnt == (r_k_len - KW'(1))) begin
            w_k_cnt_nxt = '0;
            w_state_nxt = S_ROUND;
          end else begin
            w_k_cnt_nxt = r_k_cnt + KW'(1);
          end
        end
      end
      S_ROUND: begin
        if (r_acc_cnt == r_acc_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_acc_cnt_nxt = r_acc_cnt + AW'(1);
          w_state_nxt   = S_MAC;
        end
      end
      S_DRAIN: begin
        if (w_ret_sum == w_acc_total) begin
          w_state_nxt = S_DONE;
        end else if (r_drain_cnt == DCW'(DRAIN_MAX)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DCW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including the final fire and DONE
    if (w_busy && i_abort) begin
      w_state_nxt     = S_IDLE;
      w_acc_cnt_nxt   = '0;
      w_k_cnt_nxt     = '0;
      w_ret_cnt_nxt   = '0;
      w_drain_cnt_nxt = '0;
    end
  end

endmodule

// File: doc/pe_array_sched.md
# pe_array_sched

Job scheduler for the 2x16 PE array. It takes a job descriptor (accumulators used, MAC steps per accumulator) and accepts input/weight beats from the operand buffer with a valid/ready handshake. It drives the array's `add_number`, `keep` and `rounder_en` controls in the same cycle as the beat, and counts `rounder_valid` returns to signal job completion. Operand data goes straight from the buffer to the array; this block carries only control.

## Interface
- `KW`, default 8: width of the MAC-step count.
- `DRAIN_MAX`, default 15: maximum cycles in DRAIN before a timeout error.
- `clk` in 1: clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: job request. Sampled only in IDLE.
- `cfg_k_len` in KW: MAC steps per accumulator (K). Must be ≥1. Latched on start.
- `cfg_acc_num` in 4: number of accumulators minus 1, so A = cfg_acc_num+1 (1..16). Latched on start.
- `abort` in 1: synchronous job kill.
- `in_valid` in 1: operand buffer presents a beat.
- `in_ready` out 1: controller accepts the beat (fire = in_valid & in_ready).
- `pe_add_number` out 4: accumulator select to the array.
- `pe_keep` out 1: hold all accumulators.
- `pe_rounder_en` out 1: rounding request to the array.
- `pe_rounder_valid` in 1: rounding result from the array.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky drain timeout. Cleared by the next accepted start or by rst.

## Operation
- States: IDLE, MAC, ROUND, DRAIN, DONE.
- Registers:
  - acc_cnt (4b): current accumulator.
  - k_cnt (KW): beats taken for the current accumulator.
  - ret_cnt (5b): rounder_valid pulses received.
  - drain_cnt: cycles spent in DRAIN.
- IDLE:
  - On start=1 with cfg_k_len≠0: latch cfg, clear acc_cnt, k_cnt, ret_cnt and err, go to MAC.
  - start with cfg_k_len=0 is ignored; no done, no err.
- MAC:
  - in_ready=1.
  - Each fire increments k_cnt.
  - On the fire with k_cnt=K-1: clear k_cnt and go to ROUND.
  - A cycle with no fire leaves the counters unchanged.
- ROUND: lasts exactly one cycle, with in_ready=0.
  - If acc_cnt = A-1: go to DRAIN.
  - Otherwise: increment acc_cnt and go to MAC.
- DRAIN:
  - When ret_cnt = A (including a return arriving this cycle), go to DONE.
  - If drain_cnt reaches DRAIN_MAX first: set err and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Control decode is combinational from registered state, counters and in_valid:
  - pe_add_number = acc_cnt in MAC and ROUND, 0 otherwise.
  - pe_keep = ~(state=MAC & in_valid).
  - pe_rounder_en = (state=ROUND).
- ret_cnt increments on every pe_rounder_valid while busy. Pulses seen in IDLE are ignored.
- abort=1 while busy: next state is IDLE, counters are cleared, no done, err unchanged. An abort in the same cycle as the final fire or the DONE cycle still wins.
- start while busy is ignored.

## Timing
- Reset values: in_ready=0, pe_add_number=0, pe_keep=1, pe_rounder_en=0, busy=0, done=0, err=0. State is IDLE.
- start accepted in cycle t: MAC begins at t+1, with in_ready=1 in t+1.
- With in_valid held high, MAC+ROUND takes A·(K+1) cycles.
- The control outputs have zero latency relative to the beat they qualify, so the array sees data and add_number/keep in the same cycle.
- done asserts the cycle after the A-th return is counted. busy falls the cycle after done.
- Reset asserted mid-job: outputs go to reset values immediately, without waiting for a clock edge.
- Counter widths: K up to 2^KW-1. k_cnt compares against K-1 and never wraps within an accumulator.

## Test plan
- K=4, A=2, in_valid always high, array model returns rounder_valid 3 cycles after rounder_en, start at cycle 0:
  - MAC with add_number=0 in cycles 1–4; ROUND in cycle 5.
  - MAC with add_number=1 in cycles 6–9; ROUND in cycle 10.
  - Returns at cycles 8 and 13; done=1 in cycle 14; busy=0 in cycle 15.
- Same job with in_valid low on alternate cycles: exactly 4 fires per accumulator, pe_keep=1 in every idle cycle, rounder_en only after the 4th fire.
- cfg_k_len=0 with start=1: busy stays 0, done never pulses.
- abort in cycle 3 of the first test: busy=0 in cycle 4. A new start in cycle 5 runs cleanly and done follows the first-test schedule shifted by 5.
- Array model suppresses returns: err=1 and done=1 DRAIN_MAX+1 cycles after entering DRAIN. The next start clears err.
- rst pulsed during MAC: pe_keep=1 and busy=0 immediately, before the next clock edge.
